id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage sitting directly upstream of the 64-bit ALU: captures decoded operands and control from the decode stage and generates the registered 4-bit ALU control code from main ALUOp/funct3/funct7. It drives the ALU operand inputs through EX/MEM and MEM/WB forwarding muxes. It also detects load-use hazards, stalling decode and injecting bubbles, and honours branch flushes from the downstream branch-resolution logic.

## Interface
- XLEN, 64, datapath width
- RW, 5, register-index width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded values
- id_rs1, id_rs2, id_rd  in  RW each  register indices
- id_funct3  in  3; id_funct7_b5  in  1  instruction function bits
- id_alu_op  in  2  main control: 00 add, 01 branch/sub, 10 R-type, 11 reserved
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each
- flush  in  1  branch taken downstream; kill ID/EX contents
- exmem_rd  in  RW; exmem_reg_write  in  1; exmem_result  in  XLEN  forwarding source 1
- memwb_rd  in  RW; memwb_reg_write  in  1; memwb_result  in  XLEN  forwarding source 2
- stall_id  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1; ex_pc  out  XLEN
- ex_a, ex_b  out  XLEN  ALU operands (after forwarding)
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_alu_ctl  out  4  ALU op code
- ex_rd  out  RW; ex_funct3  out  3
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each

## Operation
- ALU control, computed from id_* and registered:
  - alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0010.
  - alu_op 10 by funct3: 000 -> 0110 if funct7_b5 else 0010; 111 -> 0000; 110 -> 0001; any other -> 1100 (nor).
- Load-use hazard (combinational): stall_id = id_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- Register update priority at each rising edge:
  - reset: all registered fields 0.
  - else flush: bubble.
  - else stall_id: bubble; decode holds, so the same instruction is re-presented next cycle.
  - else: capture all id_* fields; ex_valid = id_valid.
- Bubble: ex_valid = 0 and all control outputs = 0 (no reg_write/mem_* side effects); data fields don't-care, driven 0.
- Forwarding, combinational on registered rs1/rs2 (same rule per source):
  - Select exmem_result if exmem_reg_write & exmem_rd≠0 & exmem_rd==rs.
  - Else memwb_result under the same rule for memwb.
  - Else the registered register data.
  - EX/MEM wins when both match; x0 is never forwarded.
- ex_a = fwd(rs1); ex_b = ex_alu_src ? ex_imm : fwd(rs2); ex_store_data = fwd(rs2) regardless of alu_src.
- Widths: all data paths are XLEN; no sign manipulation here, since immediates arrive pre-extended.

## Timing
- Latency 1 cycle from id_* to registered ex_* fields. ex_a/ex_b/ex_store_data also depend combinationally on same-cycle forwarding inputs.
- stall_id is asserted in the same cycle the hazard exists and drops after exactly one bubble (the load has then advanced to MEM/WB and is forwarded).
- flush and stall_id together: flush wins; bubble inserted, and stall_id still asserts combinationally (harmless, since IF/ID is flushed too).
- reset mid-stream: next edge yields ex_valid = 0 and all outputs 0; stall_id = 0 while ex is empty.
- Back-to-back valid instructions with no hazard: one per cycle, no gaps.

## Structure
- Shared package alu_pkg holds:
  - ALU code constants: ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_NOR = 4'b1100.
  - Main ALUOp constants: AOP_MEM = 2'b00, AOP_BR = 2'b01, AOP_R = 2'b10.
  - XLEN default.
- One sub-module: alu_control (combinational ALUOp/funct decode), instantiated on the id_* side; forwarding and hazard logic stay inline.

## Test plan
- R-type sub: alu_op 10, funct3 000, funct7_b5 1, rs1_data 9, rs2_data 4 -> next cycle ex_alu_ctl 0110, ex_a 9, ex_b 4, ex_valid 1.
- Forwarding priority: ex rs1 = 5; exmem_rd = 5 with result 0xAA, memwb_rd = 5 with result 0xBB, both reg_write -> ex_a 0xAA. Drop the exmem match -> ex_a 0xBB. rd = 0 on both -> registered data.
- Load-use: ld x7 in EX, next id_rs2 = 7 -> stall_id 1 for exactly one cycle; next edge ex_valid 0 with all controls 0; following edge captures the dependent instruction with ex_b = memwb_result.
- Flush: flush = 1 with valid store in ID -> next cycle ex_valid 0, ex_mem_write 0; flush plus hazard together -> bubble only.
- alu_src/store: sd with imm 16, alu_src 1, rs2 forwarded 0x1234 from EX/MEM -> ex_b 16, ex_store_data 0x1234, ex_alu_ctl 0010.
- Reset during a stall sequence -> all outputs 0 next edge, stall_id 0; unlisted funct3 100 with alu_op 10 -> ex_alu_ctl 1100.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings and datapath defaults for the ID/EX stage and ALU.
// Latency: none (constants only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int XLEN = 64;
    localparam int RW   = 5;

    // 4-bit ALU control codes consumed by the 64-bit ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Main ALUOp from the decoder; 2'b11 is reserved and treated as add
    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;

endpackage

// File: rtl/alu_control.sv
// Decodes main ALUOp plus funct3/funct7[5] into the 4-bit ALU control code.
// Latency: combinational, registered by the ID/EX stage.
// Backpressure: none; pure function of its inputs.
// Ports: alu_op/funct3/funct7_b5 in, alu_ctl out.
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_ctl
);

    always_comb begin
        alu_ctl = ALU_ADD;
        case (alu_op)
            AOP_MEM: alu_ctl = ALU_ADD;
            AOP_BR:  alu_ctl = ALU_SUB;
            AOP_R: begin
                case (funct3)
                    3'b000:  alu_ctl = funct7_b5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_ctl = ALU_AND;
                    3'b110:  alu_ctl = ALU_OR;
                    default: alu_ctl = ALU_NOR;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX operand forwarding and load-use detection.
// Latency: 1 cycle id_* -> ex_*; ex_a/ex_b/ex_store_data also follow same-cycle forwarding inputs.
// Backpressure: stall_id (combinational) holds decode for one cycle on a load-use hazard; a bubble is injected instead.
// Ports: id_* decoded instruction in; exmem_*/memwb_* forwarding sources in; flush kills ID/EX;
//        stall_id out to IF/ID; ex_* registered control/data and forwarded ALU operands out.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int RW   = alu_pkg::RW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_b5,
    input  logic [1:0]      id_alu_op,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,
    input  logic            flush,
    input  logic [RW-1:0]   exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RW-1:0]   memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [3:0]      ex_alu_ctl,
    output logic [RW-1:0]   ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch
);

    logic [3:0]      id_alu_ctl;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [RW-1:0]   ex_rs1;
    logic [RW-1:0]   ex_rs2;
    logic            ex_alu_src;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    alu_control u_alu_control (
        .alu_op    (id_alu_op),
        .funct3    (id_funct3),
        .funct7_b5 (id_funct7_b5),
        .alu_ctl   (id_alu_ctl)
    );

    // A load in EX cannot forward until it reaches MEM/WB, so a dependent
    // instruction in decode must wait exactly one cycle.
    assign stall_id = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Reset, flush and load-use all collapse to the same all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || stall_id) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_funct3     <= '0;
            ex_alu_ctl    <= '0;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
        end else begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_funct3     <= id_funct3;
            ex_alu_ctl    <= id_alu_ctl;
            ex_alu_src    <= id_alu_src;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_branch     <= id_branch;
        end
    end

    // EX/MEM is the younger producer, so it is checked first; x0 never forwards.
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs1))
            fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs1))
            fwd_rs1 = memwb_result;
    end

    always_comb begin
        fwd_rs2 = ex_rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs2))
            fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs2))
            fwd_rs2 = memwb_result;
    end

    assign ex_a          = fwd_rs1;
    assign ex_b          = ex_alu_src ? ex_imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7_b5;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic        flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [63:0] exmem_result, memwb_result;
    logic        stall_id, ex_valid;
    logic [63:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctl;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_ctl(ex_alu_ctl), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    // Reference view of the instruction sitting in EX
    typedef struct {
        bit        valid;
        bit [63:0] pc, rs1d, rs2d, imm;
        bit [4:0]  rs1, rs2, rd;
        bit [2:0]  f3;
        bit [3:0]  ctl;
        bit        src, mr, mw, rw, mtr, br;
    } ex_slot_t;

    ex_slot_t m, m_nxt;
    int total = 0;
    int bad   = 0;

    function automatic ex_slot_t empty_slot();
        ex_slot_t s;
        s = '{valid: 0, pc: 0, rs1d: 0, rs2d: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
              f3: 0, ctl: 0, src: 0, mr: 0, mw: 0, rw: 0, mtr: 0, br: 0};
        return s;
    endfunction

    // ALU code straight from the decode table
    function automatic bit [3:0] exp_ctl(bit [1:0] op, bit [2:0] f3, bit f7);
        if (op == 2'd1) return 4'b0110;
        if (op != 2'd2) return 4'b0010;
        if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
        if (f3 == 3'd7) return 4'b0000;
        if (f3 == 3'd6) return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic bit [63:0] exp_fwd(bit [4:0] rs, bit [63:0] regval);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
        return regval;
    endfunction

    function automatic bit exp_stall();
        return id_valid && m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic compare_all();
        check("stall_id", stall_id, exp_stall());
        check("ex_valid", ex_valid, m.valid);
        check("ex_pc", ex_pc, m.pc);
        check("ex_a", ex_a, exp_fwd(m.rs1, m.rs1d));
        check("ex_b", ex_b, m.src ? m.imm : exp_fwd(m.rs2, m.rs2d));
        check("ex_store_data", ex_store_data, exp_fwd(m.rs2, m.rs2d));
        check("ex_alu_ctl", ex_alu_ctl, m.ctl);
        check("ex_rd", ex_rd, m.rd);
        check("ex_funct3", ex_funct3, m.f3);
        check("ex_ctrl", {ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch},
              {m.mr, m.mw, m.rw, m.mtr, m.br});
    endtask

    function automatic ex_slot_t next_slot();
        ex_slot_t s;
        if (reset || flush || exp_stall()) return empty_slot();
        s.valid = id_valid; s.pc = id_pc; s.rs1d = id_rs1_data; s.rs2d = id_rs2_data;
        s.imm = id_imm; s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd; s.f3 = id_funct3;
        s.ctl = exp_ctl(id_alu_op, id_funct3, id_funct7_b5);
        s.src = id_alu_src; s.mr = id_mem_read; s.mw = id_mem_write; s.rw = id_reg_write;
        s.mtr = id_mem_to_reg; s.br = id_branch;
        return s;
    endfunction

    // Check the current cycle against the model, then advance one edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        m_nxt = next_slot();
        @(posedge clk);
        m = m_nxt;
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_b5 = 0;
        id_alu_op = 0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
        id_mem_to_reg = 0; id_branch = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic set_instr(bit [1:0] op, bit [2:0] f3, bit f7, bit [4:0] rs1, bit [4:0] rs2,
                             bit [4:0] rd, bit [63:0] d1, bit [63:0] d2);
        id_valid = 1; id_pc = id_pc + 4; id_alu_op = op; id_funct3 = f3; id_funct7_b5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = 0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0;
        id_reg_write = 1; id_mem_to_reg = 0; id_branch = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        m = empty_slot();
        #1;
        cycle();
        reset = 0;
        check("reset_valid", ex_valid, 1'b0);
        check("reset_stall", stall_id, 1'b0);

        // R-type sub
        set_instr(2'b10, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 64'd9, 64'd4);
        cycle();
        check("sub_ctl", ex_alu_ctl, 4'b0110);
        check("sub_a", ex_a, 64'd9);
        check("sub_b", ex_b, 64'd4);
        check("sub_valid", ex_valid, 1'b1);

        // Forwarding priority on rs1 = 5
        set_instr(2'b10, 3'b111, 1'b0, 5'd5, 5'd6, 5'd8, 64'h11, 64'h22);
        cycle();
        check("and_ctl", ex_alu_ctl, 4'b0000);
        exmem_rd = 5; exmem_reg_write = 1; exmem_result = 64'hAA;
        memwb_rd = 5; memwb_reg_write = 1; memwb_result = 64'hBB;
        #1 check("fwd_exmem_wins", ex_a, 64'hAA);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", ex_a, 64'hBB);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check("fwd_x0_none", ex_a, 64'h11);
        exmem_reg_write = 0; memwb_reg_write = 0;

        // Load-use: ld x7 then dependent on rs2
        set_instr(2'b00, 3'b011, 1'b0, 5'd1, 5'd2, 5'd7, 64'h100, 64'h0);
        id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_imm = 64'd8;
        cycle();
        set_instr(2'b10, 3'b110, 1'b0, 5'd3, 5'd7, 5'd9, 64'h30, 64'h55);
        #1 check("lu_stall", stall_id, 1'b1);
        cycle();
        check("lu_bubble_valid", ex_valid, 1'b0);
        check("lu_bubble_ctrl", {ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch}, 5'b0);
        check("lu_stall_drop", stall_id, 1'b0);
        memwb_rd = 7; memwb_reg_write = 1; memwb_result = 64'h777;
        cycle();
        check("lu_dep_valid", ex_valid, 1'b1);
        check("lu_dep_b", ex_b, 64'h777);
        check("lu_or_ctl", ex_alu_ctl, 4'b0001);
        memwb_reg_write = 0;

        // Flush with a store in ID
        set_instr(2'b00, 3'b011, 1'b0, 5'd1, 5'd2, 5'd0, 64'h1, 64'h2);
        id_mem_write = 1; id_reg_write = 0; flush = 1;
        cycle();
        flush = 0;
        check("flush_valid", ex_valid, 1'b0);
        check("flush_mw", ex_mem_write, 1'b0);

        // Flush and hazard together
        set_instr(2'b00, 3'b011, 1'b0, 5'd1, 5'd2, 5'd9, 64'h1, 64'h2);
        id_mem_read = 1;
        cycle();
        set_instr(2'b10, 3'b000, 1'b0, 5'd9, 5'd2, 5'd10, 64'h1, 64'h2);
        flush = 1;
        #1 check("flush_hz_stall", stall_id, 1'b1);
        cycle();
        flush = 0;
        check("flush_hz_valid", ex_valid, 1'b0);
        check("flush_hz_mr", ex_mem_read, 1'b0);

        // Store with immediate, rs2 forwarded from EX/MEM
        set_instr(2'b00, 3'b011, 1'b0, 5'd1, 5'd6, 5'd0, 64'h40, 64'h0);
        id_alu_src = 1; id_imm = 64'd16; id_mem_write = 1; id_reg_write = 0;
        cycle();
        exmem_rd = 6; exmem_reg_write = 1; exmem_result = 64'h1234;
        #1 check("sd_b", ex_b, 64'd16);
        check("sd_store", ex_store_data, 64'h1234);
        check("sd_ctl", ex_alu_ctl, 4'b0010);
        exmem_reg_write = 0;

        // Reset in the middle of a stall
        set_instr(2'b00, 3'b011, 1'b0, 5'd1, 5'd2, 5'd4, 64'h1, 64'h2);
        id_mem_read = 1;
        cycle();
        set_instr(2'b10, 3'b000, 1'b0, 5'd4, 5'd2, 5'd11, 64'h1, 64'h2);
        #1 check("rst_pre_stall", stall_id, 1'b1);
        reset = 1;
        cycle();
        reset = 0;
        check("rst_valid", ex_valid, 1'b0);
        check("rst_outs", {ex_pc, ex_a, ex_b, ex_store_data}, 256'b0);
        check("rst_ctl", {ex_alu_ctl, ex_rd, ex_funct3, ex_mem_read, ex_mem_write}, 14'b0);
        check("rst_stall", stall_id, 1'b0);

        // Unlisted R-type funct3 decodes to nor
        set_instr(2'b10, 3'b100, 1'b0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2);
        cycle();
        check("nor_ctl", ex_alu_ctl, 4'b1100);

        // Randomized traffic, small register space so hazards and forwarding are frequent
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 4) != 0);
            id_pc = {$urandom, $urandom};
            id_rs1_data = {$urandom, $urandom};
            id_rs2_data = {$urandom, $urandom};
            id_imm = {$urandom, $urandom};
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_funct3 = 3'($urandom);
            id_funct7_b5 = 1'($urandom);
            id_alu_op = 2'($urandom);
            id_alu_src = 1'($urandom);
            id_mem_read = ($urandom_range(0, 2) == 0);
            id_mem_write = 1'($urandom);
            id_reg_write = 1'($urandom);
            id_mem_to_reg = 1'($urandom);
            id_branch = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 7));
            exmem_reg_write = 1'($urandom);
            exmem_result = {$urandom, $urandom};
            memwb_rd = 5'($urandom_range(0, 7));
            memwb_reg_write = 1'($urandom);
            memwb_result = {$urandom, $urandom};
            cycle();
        end
        @(negedge clk);
        compare_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
